// File: rtl/sd_block_reader.sv
// sd_block_reader
// Drives an SPI byte shifter through a single-block SD read in SPI mode:
// dummy byte, CMD17, R1 poll, data-token wait, payload stream, CRC, trailer.
//
// Optional feature macro: SD_BLOCK_READER_CRC_CHECK_EN
//   When defined, CRC-16/XMODEM is computed over the accepted payload and
//   checked against the two trailing CRC bytes (err=5 on mismatch).
//   When undefined, the CRC bytes are clocked and discarded.
//
// Handshakes used by this block:
//   SPI byte link: spi_start is a one-cycle pulse with spi_tx stable. After
//   it, exactly one byte is outstanding until spi_done pulses (spi_rx valid
//   that cycle). spi_done with nothing outstanding is ignored. The next
//   spi_start is never issued in the same cycle as spi_done.
//   Payload link: data_out/data_valid are held until data_valid & data_ready
//   is sampled on a rising edge; no new SPI byte starts while a payload byte
//   is held.
module sd_block_reader #(
  parameter int BLOCK_BYTES   = 512,
  parameter int R1_POLL_MAX   = 8,
  parameter int TOKEN_TIMEOUT = 65535
) (
  input  logic        C100M,
  input  logic        RESET,
  input  logic        cmd_start,
  input  logic [31:0] cmd_lba,
  input  logic        cmd_sdhc,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [7:0]  r1,
  output logic        cs_assert,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_CMD   = 3'd2,
    S_R1    = 3'd3,
    S_TOKEN = 3'd4,
    S_DATA  = 3'd5,
    S_CRC   = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_R1_TO   = 3'd1;
  localparam logic [2:0] ERR_R1_BAD  = 3'd2;
  localparam logic [2:0] ERR_TOKEN   = 3'd3;
  localparam logic [2:0] ERR_TOK_TO  = 3'd4;
  localparam logic [2:0] ERR_CRC     = 3'd5;

  // Terminal values of the shared byte counter and the token poll counter.
  localparam logic [11:0] LAST_BYTE = 12'(BLOCK_BYTES - 1);
  localparam logic [11:0] LAST_POLL = 12'(R1_POLL_MAX - 1);
  localparam logic [15:0] LAST_TOK  = 16'(TOKEN_TIMEOUT - 1);
  localparam logic [11:0] LAST_CMD  = 12'd5;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  err_q;
  logic [7:0]  r1_q;
  logic        cs_q;
  logic        start_q;
  logic [7:0]  tx_q;
  logic [7:0]  dout_q;
  logic        dv_q;
  logic        pend_q;    // one SPI byte outstanding
  logic [31:0] arg_q;
  logic [11:0] cnt_q;     // CMD byte index, R1 poll count, payload and CRC byte index
  logic [15:0] tok_q;     // token poll count

  logic [7:0]  tx_d;
  logic        cmd_go;
  logic        accept;
  logic        crc_bad;

  assign cmd_go = (state_q == S_IDLE) && cmd_start;
  assign accept = dv_q && data_ready;

  // Byte to shift next: the CMD17 frame while in CMD, idle 0xFF otherwise.
  always_comb begin
    tx_d = 8'hFF;
    if (state_q == S_CMD) begin
      case (cnt_q[2:0])
        3'd0:    tx_d = 8'h51;
        3'd1:    tx_d = arg_q[31:24];
        3'd2:    tx_d = arg_q[23:16];
        3'd3:    tx_d = arg_q[15:8];
        3'd4:    tx_d = arg_q[7:0];
        default: tx_d = 8'hFF;
      endcase
    end
  end

`ifdef SD_BLOCK_READER_CRC_CHECK_EN
  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [7:0]  crc_hi_q;

  // CRC-16/XMODEM, one byte at a time, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Next CRC value once the held payload byte is consumed.
  always_comb crc_d = crc16_byte(crc_q, dout_q);

  // Running CRC over accepted payload bytes, cleared at each new command.
  always_ff @(posedge C100M or posedge RESET) begin
    if (RESET) begin
      crc_q <= 16'h0000;
    end else if (cmd_go) begin
      crc_q <= 16'h0000;
    end else if (accept) begin
      crc_q <= crc_d;
    end
  end

  // Capture the first (high) CRC byte so the pair can be checked on the second.
  always_ff @(posedge C100M or posedge RESET) begin
    if (RESET) begin
      crc_hi_q <= 8'h00;
    end else if ((state_q == S_CRC) && pend_q && spi_done && (cnt_q == 12'd0)) begin
      crc_hi_q <= spi_rx;
    end
  end

  assign crc_bad = ({crc_hi_q, spi_rx} != crc_q);
`else
  assign crc_bad = 1'b0;
`endif

  // Read sequencer: issues one SPI byte at a time and reacts to each reply.
  always_ff @(posedge C100M or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
      r1_q    <= 8'hFF;
      cs_q    <= 1'b0;
      start_q <= 1'b0;
      tx_q    <= 8'hFF;
      dout_q  <= 8'h00;
      dv_q    <= 1'b0;
      pend_q  <= 1'b0;
      arg_q   <= 32'h0;
      cnt_q   <= 12'd0;
      tok_q   <= 16'd0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q == S_IDLE) begin
        if (cmd_start) begin
          // Byte addressing: lba * 512, keeping the low 32 bits.
          arg_q   <= cmd_sdhc ? cmd_lba : {cmd_lba[22:0], 9'd0};
          busy_q  <= 1'b1;
          err_q   <= ERR_OK;
          cnt_q   <= 12'd0;
          tok_q   <= 16'd0;
          cs_q    <= 1'b0;
          // Dummy byte goes out immediately, card still deselected.
          start_q <= 1'b1;
          tx_q    <= 8'hFF;
          pend_q  <= 1'b1;
          state_q <= S_PRE;
        end
      end else if (pend_q) begin
        if (spi_done) begin
          pend_q <= 1'b0;
          case (state_q)
            S_PRE: begin
              cs_q    <= 1'b1;
              cnt_q   <= 12'd0;
              state_q <= S_CMD;
            end
            S_CMD: begin
              if (cnt_q == LAST_CMD) begin
                cnt_q   <= 12'd0;
                state_q <= S_R1;
              end else begin
                cnt_q <= cnt_q + 12'd1;
              end
            end
            S_R1: begin
              r1_q <= spi_rx;
              if (!spi_rx[7]) begin
                if (spi_rx == 8'h00) begin
                  tok_q   <= 16'd0;
                  state_q <= S_TOKEN;
                end else begin
                  err_q   <= ERR_R1_BAD;
                  cs_q    <= 1'b0;
                  state_q <= S_FIN;
                end
              end else if (cnt_q == LAST_POLL) begin
                err_q   <= ERR_R1_TO;
                cs_q    <= 1'b0;
                state_q <= S_FIN;
              end else begin
                cnt_q <= cnt_q + 12'd1;
              end
            end
            S_TOKEN: begin
              if (spi_rx == 8'hFE) begin
                cnt_q   <= 12'd0;
                state_q <= S_DATA;
              end else if (spi_rx[7:4] == 4'h0) begin
                err_q   <= ERR_TOKEN;
                cs_q    <= 1'b0;
                state_q <= S_FIN;
              end else if (tok_q == LAST_TOK) begin
                // Every unresolved poll counts, so a stuck card cannot hang us.
                err_q   <= ERR_TOK_TO;
                cs_q    <= 1'b0;
                state_q <= S_FIN;
              end else begin
                tok_q <= tok_q + 16'd1;
              end
            end
            S_DATA: begin
              dout_q <= spi_rx;
              dv_q   <= 1'b1;
            end
            S_CRC: begin
              if (cnt_q == 12'd0) begin
                cnt_q <= 12'd1;
              end else begin
                if (crc_bad) begin
                  err_q <= ERR_CRC;
                end
                cs_q    <= 1'b0;
                state_q <= S_FIN;
              end
            end
            S_FIN: begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end else if (dv_q) begin
        // Payload byte held; only the consumer can release it.
        if (data_ready) begin
          dv_q <= 1'b0;
          if (cnt_q == LAST_BYTE) begin
            cnt_q   <= 12'd0;
            state_q <= S_CRC;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
      end else begin
        start_q <= 1'b1;
        tx_q    <= tx_d;
        pend_q  <= 1'b1;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign r1         = r1_q;
  assign cs_assert  = cs_q;
  assign spi_start  = start_q;
  assign spi_tx     = tx_q;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader with a behavioural SPI shifter/card
// model and a payload consumer. TOKEN_TIMEOUT is shortened to 16 here.
module tb_sd_block_reader;

  localparam int BLOCK_BYTES   = 512;
  localparam int R1_POLL_MAX   = 8;
  localparam int TOKEN_TIMEOUT = 16;
  localparam int BUDGET        = 20000;
  localparam logic [31:0] RESET_VEC = {1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00};

  logic        C100M;
  logic        RESET;
  logic        cmd_start;
  logic [31:0] cmd_lba;
  logic        cmd_sdhc;
  logic        busy;
  logic        done;
  logic [2:0]  err;
  logic [7:0]  r1;
  logic        cs_assert;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx = 8'hFF;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic [2:0]  dbg_state;

  sd_block_reader #(
    .BLOCK_BYTES  (BLOCK_BYTES),
    .R1_POLL_MAX  (R1_POLL_MAX),
    .TOKEN_TIMEOUT(TOKEN_TIMEOUT)
  ) dut (
    .C100M     (C100M),
    .RESET     (RESET),
    .cmd_start (cmd_start),
    .cmd_lba   (cmd_lba),
    .cmd_sdhc  (cmd_sdhc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .r1        (r1),
    .cs_assert (cs_assert),
    .spi_start (spi_start),
    .spi_tx    (spi_tx),
    .spi_done  (spi_done),
    .spi_rx    (spi_rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .dbg_state (dbg_state)
  );

  // Clock
  initial C100M = 1'b0;
  always #5 C100M = ~C100M;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rsp_q[$];
  logic [7:0] tx_log[$];
  logic       cs_log[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int   done_cnt = 0;
  int   viol_cnt = 0;
  int   dv_cnt   = 0;
  int   done_base = 0;
  int   viol_base = 0;
  int   dv_base   = 0;
  int   delay_m  = 0;
  logic [7:0] rx_m = 8'hFF;
  int   stray_req = 0;
  int   stray_ack = 0;
  logic ready_toggle = 1'b0;

  // SPI shifter + card model: replies from rsp_q (0xFF when empty), two-cycle shift.
  always @(negedge C100M) begin
    if (RESET) begin
      spi_done = 1'b0;
      delay_m  = 0;
    end else begin
      if (spi_start && (delay_m != 0 || spi_done)) viol_cnt++;
      if (spi_start && data_valid) viol_cnt++;
      spi_done = 1'b0;
      if (delay_m != 0) begin
        delay_m--;
        if (delay_m == 0) begin
          spi_done = 1'b1;
          spi_rx   = rx_m;
        end
      end else if (stray_req != stray_ack) begin
        stray_ack++;
        spi_done = 1'b1;
        spi_rx   = 8'h00;
      end
      if (spi_start) begin
        tx_log.push_back(spi_tx);
        cs_log.push_back(cs_assert);
        rx_m = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'hFF;
        delay_m = 2;
      end
    end
    if (done) done_cnt++;
    if (data_valid) dv_cnt++;
  end

  // Payload consumer: always ready, or toggling ready every cycle.
  always @(negedge C100M) begin
    data_ready = ready_toggle ? ~data_ready : 1'b1;
    if (!RESET && data_valid && data_ready) got_q.push_back(data_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-16/XMODEM reference.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int j = 7; j >= 0; j--) begin
      fb = r[15] ^ b[j];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic clear_logs();
    rsp_q.delete();
    tx_log.delete();
    cs_log.delete();
    got_q.delete();
    exp_q.delete();
    done_base = done_cnt;
    viol_base = viol_cnt;
    dv_base   = dv_cnt;
  endtask

  task automatic push_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) rsp_q.push_back(b);
  endtask

  // Payload byte i = i*mul + seed; followed by its CRC (optionally corrupted).
  task automatic push_block(input int mul, input int seed, input logic corrupt);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'h0000;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      b = 8'(i * mul + seed);
      rsp_q.push_back(b);
      exp_q.push_back(b);
      c = crc_step(c, b);
    end
    rsp_q.push_back(c[15:8]);
    rsp_q.push_back(corrupt ? (c[7:0] ^ 8'h01) : c[7:0]);
  endtask

  task automatic start_cmd(input string tag, input logic [31:0] lba, input logic sdhc);
    @(negedge C100M);
    cmd_lba   = lba;
    cmd_sdhc  = sdhc;
    cmd_start = 1'b1;
    @(negedge C100M);
    cmd_start = 1'b0;
    chk({tag, "_first_spi_start"}, {31'd0, spi_start}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < BUDGET) begin
      @(negedge C100M);
      k++;
    end
    chk({tag, "_bytes_in_budget"}, (got_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == done_base && k < BUDGET) begin
      @(negedge C100M);
      k++;
    end
    repeat (6) @(negedge C100M);
    chk({tag, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cs_after"}, {31'd0, cs_assert}, 32'd0);
    chk({tag, "_handshake_viol"}, 32'(viol_cnt - viol_base), 32'd0);
  endtask

  task automatic check_cmd(input string tag, input logic [31:0] arg);
    logic [7:0] exp_cmd [6];
    exp_cmd[0] = 8'h51;
    exp_cmd[1] = arg[31:24];
    exp_cmd[2] = arg[23:16];
    exp_cmd[3] = arg[15:8];
    exp_cmd[4] = arg[7:0];
    exp_cmd[5] = 8'hFF;
    chk({tag, "_tx_len_ge7"}, (tx_log.size() >= 7) ? 32'd1 : 32'd0, 32'd1);
    if (tx_log.size() >= 7) begin
      chk({tag, "_pre_byte"}, {24'd0, tx_log[0]}, 32'h0000_00FF);
      for (int i = 0; i < 6; i++)
        chk($sformatf("%s_cmd_byte%0d", tag, i), {24'd0, tx_log[i + 1]}, {24'd0, exp_cmd[i]});
    end
  endtask

  task automatic check_payload(input string tag);
    chk({tag, "_payload_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_payload%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  logic [2:0] exp_crc_err;

  initial begin
    RESET     = 1'b1;
    cmd_start = 1'b0;
    cmd_lba   = 32'h0;
    cmd_sdhc  = 1'b0;
`ifdef SD_BLOCK_READER_CRC_CHECK_EN
    exp_crc_err = 3'd5;
`else
    exp_crc_err = 3'd0;
`endif

    // Reset state
    repeat (3) @(negedge C100M);
    chk("reset_outputs", {busy, done, err, r1, cs_assert, spi_start, spi_tx, data_valid, data_out}, RESET_VEC);
    RESET = 1'b0;
    repeat (2) @(negedge C100M);
    chk("idle_outputs", {busy, done, err, r1, cs_assert, spi_start, spi_tx, data_valid, data_out}, RESET_VEC);

    // Stray spi_done while idle is ignored
    clear_logs();
    stray_req++;
    repeat (6) @(negedge C100M);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_no_tx", 32'(tx_log.size()), 32'd0);
    chk("stray_no_done", 32'(done_cnt - done_base), 32'd0);

    // Happy path: byte addressing, R1 on poll 2, token after 3 idle bytes
    clear_logs();
    push_n(8'hFF, 7);
    push_n(8'hFF, 1);
    push_n(8'h00, 1);
    push_n(8'hFF, 3);
    push_n(8'hFE, 1);
    push_block(1, 0, 1'b0);
    start_cmd("happy", 32'h0000_0010, 1'b0);
    wait_done("happy");
    check_cmd("happy", 32'h0000_2000);
    check_payload("happy");
    chk("happy_err", {29'd0, err}, 32'd0);
    chk("happy_r1", {24'd0, r1}, 32'h0000_0000);
    chk("happy_tx_count", 32'(tx_log.size()), 32'd528);
    chk("happy_cs_pre", {31'd0, cs_log[0]}, 32'd0);
    chk("happy_cs_cmd", {31'd0, cs_log[1]}, 32'd1);
    chk("happy_cs_trailer", {31'd0, cs_log[cs_log.size() - 1]}, 32'd0);

    // SDHC argument, backpressure, ignored cmd_start mid-DATA
    clear_logs();
    ready_toggle = 1'b1;
    push_n(8'hFF, 7);
    push_n(8'h00, 1);
    push_n(8'hFE, 1);
    push_block(3, 17, 1'b0);
    start_cmd("sdhc", 32'h1234_5678, 1'b1);
    wait_bytes("sdhc", 40);
    @(negedge C100M);
    cmd_lba   = 32'hDEAD_BEEF;
    cmd_sdhc  = 1'b0;
    cmd_start = 1'b1;
    @(negedge C100M);
    cmd_start = 1'b0;
    chk("sdhc_busy_mid", {31'd0, busy}, 32'd1);
    wait_done("sdhc");
    ready_toggle = 1'b0;
    check_cmd("sdhc", 32'h1234_5678);
    check_payload("sdhc");
    chk("sdhc_err", {29'd0, err}, 32'd0);
    chk("sdhc_tx_count", 32'(tx_log.size()), 32'd524);

    // R1 timeout: card never answers
    clear_logs();
    start_cmd("r1to", 32'h0000_0001, 1'b1);
    wait_done("r1to");
    chk("r1to_err", {29'd0, err}, 32'd1);
    chk("r1to_tx_count", 32'(tx_log.size()), 32'd16);
    chk("r1to_r1", {24'd0, r1}, 32'h0000_00FF);
    chk("r1to_no_valid", 32'(dv_cnt - dv_base), 32'd0);

    // R1 nonzero
    clear_logs();
    push_n(8'hFF, 8);
    push_n(8'h05, 1);
    start_cmd("r1bad", 32'h0000_0002, 1'b1);
    wait_done("r1bad");
    chk("r1bad_err", {29'd0, err}, 32'd2);
    chk("r1bad_r1", {24'd0, r1}, 32'h0000_0005);
    chk("r1bad_tx_count", 32'(tx_log.size()), 32'd10);
    chk("r1bad_no_valid", 32'(dv_cnt - dv_base), 32'd0);

    // Error token
    clear_logs();
    push_n(8'hFF, 7);
    push_n(8'h00, 1);
    push_n(8'hFF, 1);
    push_n(8'h08, 1);
    start_cmd("tokerr", 32'h0000_0003, 1'b1);
    wait_done("tokerr");
    chk("tokerr_err", {29'd0, err}, 32'd3);
    chk("tokerr_tx_count", 32'(tx_log.size()), 32'd11);
    chk("tokerr_no_valid", 32'(dv_cnt - dv_base), 32'd0);

    // Token timeout after 16 idle polls
    clear_logs();
    push_n(8'hFF, 7);
    push_n(8'h00, 1);
    start_cmd("tokto", 32'h0000_0004, 1'b1);
    wait_done("tokto");
    chk("tokto_err", {29'd0, err}, 32'd4);
    chk("tokto_tx_count", 32'(tx_log.size()), 32'd25);
    chk("tokto_no_valid", 32'(dv_cnt - dv_base), 32'd0);

    // Reset mid-DATA, then a clean command
    clear_logs();
    push_n(8'hFF, 7);
    push_n(8'h00, 1);
    push_n(8'hFE, 1);
    push_block(1, 5, 1'b0);
    start_cmd("rst", 32'h0000_0010, 1'b0);
    wait_bytes("rst", 20);
    @(negedge C100M);
    #1;
    RESET = 1'b1;
    #1;
    chk("rst_outputs", {busy, done, err, r1, cs_assert, spi_start, spi_tx, data_valid, data_out}, RESET_VEC);
    repeat (3) @(negedge C100M);
    chk("rst_no_done", 32'(done_cnt - done_base), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge C100M);
    clear_logs();
    push_n(8'hFF, 7);
    push_n(8'h00, 1);
    push_n(8'hFE, 1);
    push_block(5, 9, 1'b0);
    start_cmd("after_rst", 32'h0000_0001, 1'b0);
    wait_done("after_rst");
    check_cmd("after_rst", 32'h0000_0200);
    check_payload("after_rst");
    chk("after_rst_err", {29'd0, err}, 32'd0);

    // Corrupted CRC low byte: payload still delivered in full
    clear_logs();
    push_n(8'hFF, 7);
    push_n(8'h00, 1);
    push_n(8'hFE, 1);
    push_block(11, 200, 1'b1);
    start_cmd("crcbad", 32'h0000_0020, 1'b1);
    wait_done("crcbad");
    check_cmd("crcbad", 32'h0000_0020);
    check_payload("crcbad");
    chk("crcbad_err", {29'd0, err}, {29'd0, exp_crc_err});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_block_reader.md
Name: sd_block_reader

Overview:
- Hardware sequencer that drives the SPI byte-shift engine to read one SD card block in SPI mode without CPU byte-banging.
- Sequence: dummy byte, CMD17, R1 poll, data-token wait, payload streaming, CRC bytes, trailer.
- Sits between the CPU register file (command/status) and the SPI shifter; the shifter's slave select is owned by this block while it is busy.

Parameters:
- BLOCK_BYTES, 512, payload bytes per block; legal range 1..4095.
- R1_POLL_MAX, 8, maximum 0xFF bytes sent while waiting for R1.
- TOKEN_TIMEOUT, 65535, maximum 0xFF bytes sent while waiting for the data token; 16-bit counter.

Ports:
- C100M  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- cmd_start  in  1  one-cycle pulse; ignored unless busy=0
- cmd_lba  in  32  block address, sampled on accepted cmd_start
- cmd_sdhc  in  1  1: block addressing (arg=lba); 0: byte addressing (arg=lba<<9, low 32 bits); sampled with cmd_start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of operation, success or error
- err  out  3  0 ok, 1 R1 timeout, 2 R1 nonzero, 3 error token, 4 token timeout, 5 CRC error; held until next start
- r1  out  8  last R1 byte received, held
- cs_assert  out  1  slave-select request to the SPI block
- spi_start  out  1  one-cycle request to shift spi_tx
- spi_tx  out  8  byte to transmit
- spi_done  in  1  one-cycle pulse from the shifter; spi_rx valid that cycle
- spi_rx  in  8  received byte
- data_out  out  8  payload byte
- data_valid  out  1  payload byte valid
- data_ready  in  1  consumer accepts when valid&ready

Behaviour:
- Reset values: busy=0, done=0, err=0, r1=0xFF, cs_assert=0, spi_start=0, spi_tx=0xFF, data_valid=0, data_out=0. Reset mid-transfer aborts immediately; no done pulse is issued.
- Byte handshake:
  - At most one byte is outstanding.
  - spi_start pulses one cycle with spi_tx stable, then the block waits for spi_done.
  - The next spi_start may issue no earlier than the cycle after spi_done.
  - spi_done while no byte is outstanding is ignored.
- FSM states and transitions:
  - IDLE: on cmd_start, latch the argument, set busy=1, clear err, go to PRE.
  - PRE: send 0xFF with cs_assert=0, then raise cs_assert, go to CMD.
  - CMD: send 6 bytes: 0x51, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 0xFF. Go to R1.
  - R1: send 0xFF and capture rx into r1.
    - rx[7]=0 and rx=0x00: go to TOKEN.
    - rx[7]=0 and rx nonzero: err=2, go to FIN.
    - After R1_POLL_MAX bytes with rx[7]=1: err=1, go to FIN.
  - TOKEN: send 0xFF.
    - rx=0xFE: go to DATA.
    - rx[7:4]=0: err=3, go to FIN.
    - rx=0xFF: keep polling; after TOKEN_TIMEOUT polls, err=4, go to FIN.
    - Any other value: keep polling.
  - DATA: send 0xFF; each rx is presented on data_out with data_valid=1.
    - The next byte is not started until that byte is accepted (valid&ready).
    - The byte counter wraps to CRC after BLOCK_BYTES accepted bytes.
    - data_valid is never asserted outside DATA.
  - CRC: send 2 bytes of 0xFF, go to FIN.
  - FIN: drop cs_assert, send one 0xFF trailer, then pulse done, busy=0, return to IDLE.
- cmd_start while busy is ignored with no side effects.
- Latency from cmd_start to the first spi_start is 1 cycle.
- Error paths skip DATA/CRC but still run FIN, so the card is always deselected with a trailer clock.

Optional Feature:
- Macro SD_BLOCK_READER_CRC_CHECK_EN.
- Defined:
  - CRC-16/XMODEM (poly 0x1021, init 0x0000) is computed bytewise over accepted payload bytes.
  - The 2 CRC bytes (MSB first) are compared against it; a mismatch sets err=5.
  - Payload already streamed is not retracted.
- Undefined: CRC bytes are clocked and discarded, err=5 never occurs, and no CRC logic is synthesised.

Test Plan:
- Happy path: lba=0x00000010, sdhc=0; card model returns R1=0x00 on poll 2, 0xFE after 3 idle bytes, 512 incrementing bytes, then CRC → CMD bytes 51 00 00 20 00 FF; 512 bytes out in order; err=0; exactly one done; cs_assert low after.
- SDHC argument plus backpressure: lba=0x12345678, sdhc=1, data_ready toggled every other cycle → CMD bytes 51 12 34 56 78 FF; no byte lost or duplicated; no spi_start while a payload byte is unaccepted.
- R1 errors: card always 0xFF → err=1 after exactly 8 polls; card returns 0x05 → err=2, r1=0x05; neither case asserts data_valid.
- Token errors: card returns error token 0x08 → err=3; card returns 0xFF forever → err=4 after 65535 polls (TOKEN_TIMEOUT overridden to 16 in a fast variant).
- Busy and reset: cmd_start pulsed mid-DATA → ignored; RESET asserted mid-DATA → all outputs at reset values the same cycle, then a new command completes normally.
- CRC (macro defined): a correct CRC gives err=0; a corrupted CRC low byte gives err=5 with all 512 bytes still delivered.
